// File: rtl/menu_countdown_ctrl_pkg.sv
// Shared encodings and helpers for the lobby/countdown sequencer.
package menu_countdown_ctrl_pkg;

  typedef enum logic [1:0] {
    LOBBY     = 2'd0,
    ARMED     = 2'd1,
    COUNTDOWN = 2'd2,
    RUNNING   = 2'd3
  } state_e;

  localparam logic [2:0] COUNTDOWN_MAX = 3'd7;

  // Bit positions of each player in the ready/button vectors
  localparam int unsigned RED    = 0;
  localparam int unsigned BLUE   = 1;
  localparam int unsigned GREEN  = 2;
  localparam int unsigned YELLOW = 3;

  // Number of joined players in a 4-bit flag vector
  function automatic logic [2:0] count_ones(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/menu_countdown_ctrl_if.sv
// Player buttons, race feedback and renderer-facing outputs of the lobby sequencer.
interface menu_countdown_ctrl_if;

  logic       btn_red;
  logic       btn_blue;
  logic       btn_green;
  logic       btn_yellow;
  logic       game_over;
  logic       red_ready_to_play;
  logic       blue_ready_to_play;
  logic       green_ready_to_play;
  logic       yellow_ready_to_play;
  logic [2:0] countdown;
  logic       menu_enable;
  logic       game_start;

  // Stimulus side: buttons and race logic
  modport master (
    output btn_red, btn_blue, btn_green, btn_yellow, game_over,
    input  red_ready_to_play, blue_ready_to_play, green_ready_to_play, yellow_ready_to_play,
    input  countdown, menu_enable, game_start
  );

  // Sequencer side
  modport slave (
    input  btn_red, btn_blue, btn_green, btn_yellow, game_over,
    output red_ready_to_play, blue_ready_to_play, green_ready_to_play, yellow_ready_to_play,
    output countdown, menu_enable, game_start
  );

endinterface

// File: rtl/menu_countdown_ctrl_step_timer.sv
// Free-running 0..TERMINAL counter with a wrap pulse; clear wins over run.
module menu_countdown_ctrl_step_timer #(
  parameter int unsigned TERMINAL = 3,
  parameter int unsigned CountW   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic wrap
);

  logic [CountW-1:0] count_q, count_d;

  // A clear in the terminal cycle suppresses the wrap so a restart is never missed
  assign wrap = run && !clear && (count_q == CountW'(TERMINAL));

  // Next count: restart on clear or wrap, otherwise advance while running
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = wrap ? '0 : count_q + CountW'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/menu_countdown_ctrl.sv
// Lobby sequencer: latches player joins, arms, runs the 7..0 countdown, pulses game_start.
module menu_countdown_ctrl
  import menu_countdown_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned JOIN_WAIT   = 100_000_000,
  parameter int unsigned MIN_PLAYERS = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  menu_countdown_ctrl_if.slave bus
);

  localparam int unsigned StepW = $clog2(STEP_CYCLES);
  localparam int unsigned WaitW = $clog2(JOIN_WAIT);

  state_e     state_q, state_d;
  logic [3:0] btn_prev_q;
  logic [3:0] ready_q, ready_d;
  logic [2:0] countdown_q, countdown_d;
  logic       menu_enable_q, menu_enable_d;
  logic       game_start_q, game_start_d;

  logic [3:0] btn_now;
  logic [3:0] rise;
  logic       join_ok;
  logic       new_join;
  logic       wait_clear, wait_run, wait_wrap;
  logic       step_clear, step_run, step_wrap;

  // Gather buttons into a player-indexed vector and find rising edges
  always_comb begin
    btn_now         = '0;
    btn_now[RED]    = bus.btn_red;
    btn_now[BLUE]   = bus.btn_blue;
    btn_now[GREEN]  = bus.btn_green;
    btn_now[YELLOW] = bus.btn_yellow;
    rise            = btn_now & ~btn_prev_q;
    join_ok         = (state_q != RUNNING);
    // Only a flag that actually changes counts as a new join for the wait restart
    new_join        = join_ok && |(rise & ~ready_q);
  end

  // Timer controls: each timer runs only in its own state and sits cleared elsewhere
  always_comb begin
    wait_run   = (state_q == ARMED);
    wait_clear = (state_q != ARMED) || new_join;
    step_run   = (state_q == COUNTDOWN);
    step_clear = (state_q != COUNTDOWN);
  end

  menu_countdown_ctrl_step_timer #(
    .TERMINAL (JOIN_WAIT - 1),
    .CountW   (WaitW)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (wait_clear),
    .run   (wait_run),
    .wrap  (wait_wrap)
  );

  menu_countdown_ctrl_step_timer #(
    .TERMINAL (STEP_CYCLES - 1),
    .CountW   (StepW)
  ) u_step_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (step_clear),
    .run   (step_run),
    .wrap  (step_wrap)
  );

  // Next-state, join flags and registered renderer outputs
  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    countdown_d   = countdown_q;
    menu_enable_d = menu_enable_q;
    game_start_d  = 1'b0;

    if (join_ok) begin
      ready_d = ready_q | rise;
    end

    unique case (state_q)
      LOBBY: begin
        countdown_d = COUNTDOWN_MAX;
        if (count_ones(ready_q) >= 3'(MIN_PLAYERS)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        countdown_d = COUNTDOWN_MAX;
        if ((ready_q == 4'hF) || wait_wrap) begin
          state_d = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        if (step_wrap) begin
          if (countdown_q == 3'd0) begin
            state_d       = RUNNING;
            game_start_d  = 1'b1;
            menu_enable_d = 1'b0;
          end else begin
            countdown_d = countdown_q - 3'd1;
          end
        end
      end
      RUNNING: begin
        countdown_d = 3'd0;
        if (bus.game_over) begin
          state_d       = LOBBY;
          ready_d       = '0;
          countdown_d   = COUNTDOWN_MAX;
          menu_enable_d = 1'b1;
        end
      end
      default: state_d = LOBBY;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= LOBBY;
      btn_prev_q    <= '0;
      ready_q       <= '0;
      countdown_q   <= COUNTDOWN_MAX;
      menu_enable_q <= 1'b1;
      game_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_prev_q    <= btn_now;
      ready_q       <= ready_d;
      countdown_q   <= countdown_d;
      menu_enable_q <= menu_enable_d;
      game_start_q  <= game_start_d;
    end
  end

  assign bus.red_ready_to_play    = ready_q[RED];
  assign bus.blue_ready_to_play   = ready_q[BLUE];
  assign bus.green_ready_to_play  = ready_q[GREEN];
  assign bus.yellow_ready_to_play = ready_q[YELLOW];
  assign bus.countdown            = countdown_q;
  assign bus.menu_enable          = menu_enable_q;
  assign bus.game_start           = game_start_q;

endmodule

// File: tb/tb_menu_countdown_ctrl.sv
// Directed bench for the lobby sequencer with STEP_CYCLES=4, JOIN_WAIT=6, MIN_PLAYERS=2.
module tb_menu_countdown_ctrl;
  import menu_countdown_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  menu_countdown_ctrl_if bus();

  menu_countdown_ctrl #(
    .STEP_CYCLES (4),
    .JOIN_WAIT   (6),
    .MIN_PLAYERS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles; inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {4'h0, bus.yellow_ready_to_play, bus.green_ready_to_play,
            bus.blue_ready_to_play, bus.red_ready_to_play};
  endfunction

  function automatic logic [7:0] st();
    return 8'(dut.state_q);
  endfunction

  initial begin
    logic [7:0] exp_cd;
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.btn_red    = 1'b0;
    bus.btn_blue   = 1'b0;
    bus.btn_green  = 1'b0;
    bus.btn_yellow = 1'b0;
    bus.game_over  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("rst_state", st(), 8'(LOBBY));
    check("rst_flags", flags(), 8'h00);
    check("rst_countdown", 8'(bus.countdown), 8'd7);
    check("rst_menu_en", 8'(bus.menu_enable), 8'd1);
    check("rst_start", 8'(bus.game_start), 8'd0);

    // Red, then blue two cycles later; arm and run the whole countdown
    bus.btn_red = 1'b1;
    tick(1);
    check("red_flag", flags(), 8'h01);
    check("red_lobby", st(), 8'(LOBBY));
    tick(1);
    bus.btn_blue = 1'b1;
    tick(1);
    check("blue_flag", flags(), 8'h03);
    check("blue_still_lobby", st(), 8'(LOBBY));
    tick(1);
    check("armed", st(), 8'(ARMED));
    check("armed_cd", 8'(bus.countdown), 8'd7);
    bus.btn_red  = 1'b0;
    bus.btn_blue = 1'b0;
    tick(5);
    check("armed_wait5", st(), 8'(ARMED));
    tick(1);
    check("cd_entry", st(), 8'(COUNTDOWN));
    for (int i = 0; i < 32; i++) begin
      exp_cd = 8'(7 - i / 4);
      check("cd_value", 8'(bus.countdown), exp_cd);
      check("cd_no_start", 8'(bus.game_start), 8'd0);
      check("cd_menu_en", 8'(bus.menu_enable), 8'd1);
      tick(1);
    end
    check("start_pulse", 8'(bus.game_start), 8'd1);
    check("start_menu_off", 8'(bus.menu_enable), 8'd0);
    check("start_cd0", 8'(bus.countdown), 8'd0);
    check("running", st(), 8'(RUNNING));
    tick(1);
    check("start_single", 8'(bus.game_start), 8'd0);

    // Press while running is ignored
    bus.btn_green = 1'b1;
    tick(1);
    check("run_press_flags", flags(), 8'h03);
    check("run_still", st(), 8'(RUNNING));
    tick(1);
    bus.btn_green = 1'b0;
    bus.game_over = 1'b1;
    tick(1);
    bus.game_over = 1'b0;
    check("go_lobby", st(), 8'(LOBBY));
    check("go_flags", flags(), 8'h00);
    check("go_cd", 8'(bus.countdown), 8'd7);
    check("go_menu_en", 8'(bus.menu_enable), 8'd1);
    bus.game_over = 1'b1;
    tick(1);
    bus.game_over = 1'b0;
    check("go_in_lobby", st(), 8'(LOBBY));
    check("go_in_lobby_flags", flags(), 8'h00);

    // Held yellow must join once only; green at wait=4 restarts the wait
    bus.btn_yellow = 1'b1;
    tick(1);
    check("yellow_flag", flags(), 8'h08);
    bus.btn_red = 1'b1;
    tick(1);
    check("yr_flags", flags(), 8'h09);
    check("yr_lobby", st(), 8'(LOBBY));
    tick(1);
    check("yr_armed", st(), 8'(ARMED));
    tick(4);
    check("wait_at4", 8'(dut.u_wait_timer.count_q), 8'd4);
    bus.btn_green = 1'b1;
    tick(1);
    check("green_flag", flags(), 8'h0D);
    check("green_restart", 8'(dut.u_wait_timer.count_q), 8'd0);
    tick(5);
    check("green_not_before", st(), 8'(ARMED));
    tick(1);
    check("green_cd_entry", st(), 8'(COUNTDOWN));
    check("green_cd7", 8'(bus.countdown), 8'd7);
    tick(5);
    check("late_cd6", 8'(bus.countdown), 8'd6);
    bus.btn_blue = 1'b1;
    tick(1);
    check("late_blue", flags(), 8'h0F);
    check("late_no_restart", 8'(bus.countdown), 8'd6);
    tick(2);
    check("late_cd5", 8'(bus.countdown), 8'd5);
    tick(9);
    check("mid_cd3", 8'(bus.countdown), 8'd3);
    bus.btn_red    = 1'b0;
    bus.btn_blue   = 1'b0;
    bus.btn_green  = 1'b0;
    bus.btn_yellow = 1'b0;
    rst_n          = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("mid_rst_state", st(), 8'(LOBBY));
    check("mid_rst_flags", flags(), 8'h00);
    check("mid_rst_cd", 8'(bus.countdown), 8'd7);
    check("mid_rst_menu_en", 8'(bus.menu_enable), 8'd1);

    // All four in one cycle: arm, then straight into the countdown
    bus.btn_red    = 1'b1;
    bus.btn_blue   = 1'b1;
    bus.btn_green  = 1'b1;
    bus.btn_yellow = 1'b1;
    tick(1);
    check("all_flags", flags(), 8'h0F);
    check("all_lobby", st(), 8'(LOBBY));
    tick(1);
    check("all_armed", st(), 8'(ARMED));
    tick(1);
    check("all_cd_entry", st(), 8'(COUNTDOWN));
    check("all_cd7", 8'(bus.countdown), 8'd7);
    bus.btn_red    = 1'b0;
    bus.btn_blue   = 1'b0;
    bus.btn_green  = 1'b0;
    bus.btn_yellow = 1'b0;
    tick(31);
    check("all_cd0", 8'(bus.countdown), 8'd0);
    check("all_no_start", 8'(bus.game_start), 8'd0);
    tick(1);
    check("all_start", 8'(bus.game_start), 8'd1);
    check("all_menu_off", 8'(bus.menu_enable), 8'd0);
    bus.game_over = 1'b1;
    tick(1);
    bus.game_over = 1'b0;
    check("all_go_lobby", st(), 8'(LOBBY));
    check("all_go_flags", flags(), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
